// File: rtl/binarize_pack.sv
// binarize_pack: thresholds signed fixed-point samples to single bits and packs
// them LSB-first into IWIDTH-bit words. A word closes when it is full or when a
// sample carries in_last, then it is held until the consumer takes it.
// Optional feature: define BINARIZE_PACK_POPCNT_EN to add the out_ones port,
// the count of 1 bits in out_data.
module binarize_pack #(
    parameter int                DWIDTH = 16,
    parameter int                IWIDTH = 64,
    parameter logic [DWIDTH-1:0] THRESH = 16'h0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [IWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef BINARIZE_PACK_POPCNT_EN
    output logic [$clog2(IWIDTH+1)-1:0] out_ones,
`endif
    output logic              out_last
);

    localparam int CW = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              in_ready_q;
    logic [IWIDTH-1:0] word_q;

    logic accept;
    logic sample_bit;
    logic word_full;
    logic release_word;

    assign accept       = in_valid & in_ready_q;
    assign sample_bit   = ($signed(in_data) >= $signed(THRESH));
    assign word_full    = (cnt_q == CW'(IWIDTH - 1));
    assign release_word = (state_q == S_HOLD) & out_ready;

    // Next-state logic: close the word on a full count or in_last, reopen when taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (word_full || in_last) begin
                        // Counter stays put so it never wraps inside a word.
                        state_d = S_HOLD;
                        last_d  = in_last;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end
            end
        endcase
    end

    // Control registers; in_ready is registered so it stays low during reset
    // and rises on the first edge afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FILL;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            in_ready_q <= (state_d == S_FILL);
        end
    end

    // One register per output bit: written when the counter points at it,
    // cleared when the held word is handed over.
    generate
        for (genvar gi = 0; gi < IWIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_q[gi] <= 1'b0;
                end else if (release_word) begin
                    word_q[gi] <= 1'b0;
                end else if (accept && (cnt_q == CW'(gi))) begin
                    word_q[gi] <= sample_bit;
                end
            end
        end
    endgenerate

`ifdef BINARIZE_PACK_POPCNT_EN
    logic [$clog2(IWIDTH+1)-1:0] ones_q;

    // Running count of 1 bits written into the current word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q <= '0;
        end else if (release_word) begin
            ones_q <= '0;
        end else if (accept && sample_bit) begin
            ones_q <= ones_q + 1'b1;
        end
    end

    assign out_ones = ones_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = word_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_binarize_pack.sv
// Self-checking bench for binarize_pack: directed vectors with hand-computed
// expectations plus a randomized handshake run against a small packing model.
// Build with BINARIZE_PACK_POPCNT_EN defined to also check out_ones.
module tb_binarize_pack;

    localparam int DW = 16;
    localparam int IW = 64;
    localparam logic signed [DW-1:0] TH = 16'sh0100;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [IW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
`ifdef BINARIZE_PACK_POPCNT_EN
    logic [6:0]    out_ones;
`endif

    binarize_pack #(.DWIDTH(DW), .IWIDTH(IW), .THRESH(16'h0100)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BINARIZE_PACK_POPCNT_EN
        .out_ones  (out_ones),
`endif
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Packing model fed by accepted samples; monitor collects handed-over words.
    logic [IW-1:0] m_word;
    int            m_cnt;
    logic [64:0]   exp_q[$];
    logic [64:0]   got_q[$];
    logic          mon_en = 1'b0;

    task automatic model_add(input logic b, input logic last);
        m_word[m_cnt] = b;
        m_cnt++;
        if (m_cnt == IW || last) begin
            exp_q.push_back({last, m_word});
            m_word = '0;
            m_cnt  = 0;
        end
    endtask

    task automatic model_reset();
        m_word = '0;
        m_cnt  = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && out_valid && out_ready)
            got_q.push_back({out_last, out_data});
    end

    // Present one sample and wait (bounded) for the edge that accepts it.
    task automatic push(input logic [DW-1:0] d, input logic last);
        logic rdy;
        int   guard;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        guard    = 0;
        do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 100);
        if (!rdy) check_val("push_timeout", 65'd0, 65'd1);
        else model_add($signed(d) >= TH, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] thr_vec [4];
    logic        done;

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_reset();
        thr_vec[0] = 16'h0100; thr_vec[1] = 16'h00FF;
        thr_vec[2] = 16'hFF00; thr_vec[3] = 16'h7FFF;

        // Reset state
        tick(); tick();
        check_val("rst_in_ready",  65'(in_ready),  65'd0);
        check_val("rst_out_valid", 65'(out_valid), 65'd0);
        check_val("rst_out_data",  65'(out_data),  65'd0);
        check_val("rst_out_last",  65'(out_last),  65'd0);
`ifdef BINARIZE_PACK_POPCNT_EN
        check_val("rst_out_ones",  65'(out_ones),  65'd0);
`endif
        rst = 1'b0;
        #2;
        check_val("ready_before_edge", 65'(in_ready), 65'd0);
        tick();
        check_val("ready_after_edge", 65'(in_ready), 65'd1);

        // Alternating 1/0 pattern, full word
        for (int i = 0; i < IW; i++) push((i % 2 == 0) ? 16'h0200 : 16'h0000, 1'b0);
        check_val("alt_valid", 65'(out_valid), 65'd1);
        check_val("alt_data",  65'(out_data),  65'(64'h5555_5555_5555_5555));
        check_val("alt_last",  65'(out_last),  65'd0);
`ifdef BINARIZE_PACK_POPCNT_EN
        check_val("alt_ones",  65'(out_ones),  65'd32);
`endif
        $display("word alt: data=%h last=%b", out_data, out_last);
        tick();
        check_val("alt_released", 65'(out_valid), 65'd0);

        // Threshold edges, short word closed by in_last
        for (int i = 0; i < 4; i++) push(thr_vec[i], i == 3);
        check_val("thr_valid", 65'(out_valid), 65'd1);
        check_val("thr_data",  65'(out_data),  65'h9);
        check_val("thr_last",  65'(out_last),  65'd1);
`ifdef BINARIZE_PACK_POPCNT_EN
        check_val("thr_ones",  65'(out_ones),  65'd2);
`endif
        $display("word thr: data=%h last=%b", out_data, out_last);
        tick();

        // Back-pressure: held word must not move and no sample consumed
        out_ready = 1'b0;
        for (int i = 0; i < IW; i++) push((i < 3) ? 16'h0200 : 16'h0000, 1'b0);
        check_val("bp_valid", 65'(out_valid), 65'd1);
        in_valid = 1'b1;
        in_data  = 16'h0200;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_data_stable", 65'(out_data),  65'h7);
            check_val("bp_in_ready",    65'(in_ready),  65'd0);
            check_val("bp_valid_held",  65'(out_valid), 65'd1);
        end
        $display("word bp: data=%h last=%b", out_data, out_last);
        out_ready = 1'b1;
        push(16'h0200, 1'b1);
        check_val("bp_next_data", 65'(out_data), 65'h1);
        check_val("bp_next_last", 65'(out_last), 65'd1);
        $display("word bp_next: data=%h last=%b", out_data, out_last);
        tick();

        // in_last on the 64th sample: one word, no empty word after
        for (int i = 0; i < IW; i++) push(16'h0200, i == IW - 1);
        check_val("full_last_data", 65'(out_data), 65'(64'hFFFF_FFFF_FFFF_FFFF));
        check_val("full_last_last", 65'(out_last), 65'd1);
        $display("word full_last: data=%h last=%b", out_data, out_last);
        tick(); tick(); tick();
        check_val("no_empty_word", 65'(out_valid), 65'd0);
        check_val("cleared_data",  65'(out_data),  65'd0);

        // Reset mid-word discards the partial word
        for (int i = 0; i < 10; i++) push(16'h0200, 1'b0);
        rst = 1'b1;
        #2;
        check_val("midrst_valid", 65'(out_valid), 65'd0);
        check_val("midrst_data",  65'(out_data),  65'd0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        check_val("midrst_valid2", 65'(out_valid), 65'd0);
        for (int i = 0; i < IW; i++) push(16'h0200, 1'b0);
        check_val("postrst_data", 65'(out_data), 65'(64'hFFFF_FFFF_FFFF_FFFF));
        check_val("postrst_last", 65'(out_last), 65'd0);
        $display("word postrst: data=%h last=%b", out_data, out_last);
        tick();

        // Randomized handshakes against the packing model
        exp_q.delete();
        got_q.delete();
        model_reset();
        mon_en = 1'b1;
        done   = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [15:0] d;
                    int gap;
                    gap = $urandom_range(0, 2);
                    for (int g = 0; g < gap; g++) tick();
                    case ($urandom_range(0, 3))
                        0:       d = 16'h0100;
                        1:       d = 16'h00FF;
                        default: d = 16'($urandom);
                    endcase
                    push(d, (i == 999) || ($urandom_range(0, 29) == 0));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        mon_en = 1'b0;
        check_val("rand_word_count", 65'(got_q.size()), 65'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            $display("word rand %0d: last=%b data=%h", i, got_q[i][64], got_q[i][63:0]);
            check_val($sformatf("rand_word_%0d", i), got_q[i], exp_q[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
